// File: rtl/optimsoc_int2ascii.sv
// Unsigned binary to fixed-width decimal ASCII converter.
// A captured value is turned into BCD by double-dabble (one input bit per
// cycle), then formatted into characters and held until the consumer takes it.
module optimsoc_int2ascii #(
  parameter int WIDTH     = 32,
  parameter int DIGITS    = 10,
  parameter int PAD_SPACE = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [WIDTH-1:0]             in_value,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [8*DIGITS-1:0]          out_string,
  output logic [$clog2(DIGITS+1)-1:0]  out_ndigits,
  output logic                         out_overflow,
  output logic                         out_valid,
  input  logic                         out_ready
);

  localparam int BCDW = 4 * DIGITS;
  localparam int CNTW = $clog2(WIDTH + 1);
  localparam int NDW  = $clog2(DIGITS + 1);

  if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
    $error("optimsoc_int2ascii: WIDTH must be in 1..64");
  end
  if (DIGITS < 1 || DIGITS > 20) begin : g_bad_digits
    $error("optimsoc_int2ascii: DIGITS must be in 1..20");
  end

  typedef enum logic [1:0] {IDLE, SHIFT, FORMAT, HOLD} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CNTW-1:0]   cnt;
  logic [BCDW-1:0]   bcd;
  logic [BCDW-1:0]   bcd_adj;
  logic [WIDTH-1:0]  val;
  logic              ovf;
  int                fmt_msd;
  logic [8*DIGITS-1:0] fmt_string;
  logic [NDW-1:0]    fmt_ndigits;

  // Double-dabble correction: any nibble of 5 or more gets +3 before the shift.
  function automatic logic [BCDW-1:0] bcd_adjust(input logic [BCDW-1:0] b);
    logic [BCDW-1:0] r;
    r = b;
    for (int i = 0; i < DIGITS; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // 1-based position of the most significant nonzero digit; zero reports 1.
  function automatic int msd_position(input logic [BCDW-1:0] b);
    int p;
    p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      if (b[4*i +: 4] != 4'd0) p = i + 1;
    end
    return p;
  endfunction

  // Characters from BCD; an overflowed value saturates to all '*'.
  function automatic logic [8*DIGITS-1:0] format_chars(input logic [BCDW-1:0] b,
                                                       input logic ovf_in,
                                                       input int msd);
    logic [8*DIGITS-1:0] s;
    s = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (ovf_in)
        s[8*i +: 8] = 8'h2A;
      else if (PAD_SPACE != 0 && i >= msd)
        s[8*i +: 8] = 8'h20;
      else
        s[8*i +: 8] = {4'h3, b[4*i +: 4]};
    end
    return s;
  endfunction

  assign bcd_adj     = bcd_adjust(bcd);
  assign fmt_msd     = msd_position(bcd);
  assign fmt_string  = format_chars(bcd, ovf, fmt_msd);
  assign fmt_ndigits = ovf ? NDW'(DIGITS) : NDW'(fmt_msd);

  assign in_ready  = rst_n && (state == IDLE);
  assign out_valid = (state == HOLD);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; SHIFT runs exactly WIDTH cycles.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = SHIFT;
      SHIFT:   if (cnt == CNTW'(1)) state_nxt = FORMAT;
      FORMAT:  state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Capture, BCD shift, and output formatting registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt          <= '0;
      bcd          <= '0;
      val          <= '0;
      ovf          <= 1'b0;
      out_string   <= '0;
      out_ndigits  <= '0;
      out_overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            val <= in_value;
            bcd <= '0;
            ovf <= 1'b0;
            cnt <= CNTW'(WIDTH);
          end
        end
        SHIFT: begin
          bcd <= {bcd_adj[BCDW-2:0], val[WIDTH-1]};
          val <= val << 1;
          ovf <= ovf | bcd_adj[BCDW-1];
          cnt <= cnt - CNTW'(1);
        end
        FORMAT: begin
          out_string   <= fmt_string;
          out_ndigits  <= fmt_ndigits;
          out_overflow <= ovf;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_optimsoc_int2ascii.sv
// Scoreboard bench: three converters (10b/3 digits zero-pad, 10b/3 digits
// space-pad, 32b/10 digits) share clock, reset and input value bus.
module tb_optimsoc_int2ascii;

  typedef struct packed {
    logic [159:0] s;
    logic [4:0]   nd;
    logic         ovf;
    logic [31:0]  acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] in_value = '0;
  logic [2:0]  iv = 3'b000;
  logic [2:0]  ordy = 3'b111;
  wire  [2:0]  ir, ov, ovfl;
  wire  [23:0] str_a, str_b;
  wire  [79:0] str_c;
  wire  [1:0]  nd_a, nd_b;
  wire  [3:0]  nd_c;
  wire  [159:0] os [3];
  wire  [4:0]   nd [3];

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  exp_t sbq [3][$];
  logic [2:0] ov_prev = 3'b000;

  always #5 clk = ~clk;

  optimsoc_int2ascii #(.WIDTH(10), .DIGITS(3), .PAD_SPACE(0)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_value(in_value[9:0]), .in_valid(iv[0]), .in_ready(ir[0]),
    .out_string(str_a), .out_ndigits(nd_a), .out_overflow(ovfl[0]), .out_valid(ov[0]),
    .out_ready(ordy[0]));

  optimsoc_int2ascii #(.WIDTH(10), .DIGITS(3), .PAD_SPACE(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_value(in_value[9:0]), .in_valid(iv[1]), .in_ready(ir[1]),
    .out_string(str_b), .out_ndigits(nd_b), .out_overflow(ovfl[1]), .out_valid(ov[1]),
    .out_ready(ordy[1]));

  optimsoc_int2ascii u_dut_c (
    .clk(clk), .rst_n(rst_n), .in_value(in_value[31:0]), .in_valid(iv[2]), .in_ready(ir[2]),
    .out_string(str_c), .out_ndigits(nd_c), .out_overflow(ovfl[2]), .out_valid(ov[2]),
    .out_ready(ordy[2]));

  assign os[0] = {136'd0, str_a};
  assign os[1] = {136'd0, str_b};
  assign os[2] = {80'd0, str_c};
  assign nd[0] = {3'd0, nd_a};
  assign nd[1] = {3'd0, nd_b};
  assign nd[2] = {1'b0, nd_c};

  function automatic int w_of(input int k);
    return (k == 2) ? 32 : 10;
  endfunction

  function automatic int dig_of(input int k);
    return (k == 2) ? 10 : 3;
  endfunction

  function automatic bit pad_of(input int k);
    return (k == 1);
  endfunction

  // Reference conversion by repeated division.
  function automatic exp_t model(input int k, input logic [63:0] v_in, input int acc);
    exp_t        e;
    logic [63:0] r;
    int          dg [20];
    int          msd;
    int          digits;
    digits = dig_of(k);
    r = v_in & ((64'd1 << w_of(k)) - 64'd1);
    msd = 1;
    e = '0;
    e.acc = 32'(acc);
    for (int i = 0; i < digits; i++) begin
      dg[i] = int'(r % 64'd10);
      r = r / 64'd10;
      if (dg[i] != 0) msd = i + 1;
    end
    if (r != 64'd0) begin
      e.ovf = 1'b1;
      e.nd = 5'(digits);
      for (int i = 0; i < digits; i++) e.s[8*i +: 8] = 8'h2A;
    end else begin
      e.nd = 5'(msd);
      for (int i = 0; i < digits; i++)
        e.s[8*i +: 8] = (pad_of(k) && i >= msd) ? 8'h20 : 8'h30 + 8'(dg[i]);
    end
    return e;
  endfunction

  task automatic check_eq(input string tag, input logic [159:0] got, input logic [159:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  // Push expectations at the accepting edge; flush on reset.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) sbq[k].delete();
      else if (iv[k] && ir[k]) sbq[k].push_back(model(k, in_value, cyc + 1));
    end
  end

  // Check latency on out_valid rise and contents on each output handshake.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (ov[k] && !ov_prev[k]) begin
        check_eq($sformatf("valid_has_pending_%0d", k), 160'(sbq[k].size() != 0), 160'd1);
        if (sbq[k].size() != 0)
          check_eq($sformatf("latency_%0d", k), 160'(cyc - int'(sbq[k][0].acc)), 160'(w_of(k) + 1));
      end
      if (ov[k] && ordy[k] && sbq[k].size() != 0) begin
        exp_t e;
        e = sbq[k].pop_front();
        check_eq($sformatf("string_%0d", k), os[k], e.s);
        check_eq($sformatf("ndigits_%0d", k), 160'(nd[k]), 160'(e.nd));
        check_eq($sformatf("overflow_%0d", k), 160'(ovfl[k]), 160'(e.ovf));
      end
    end
    ov_prev <= ov;
  end

  // Present a value and hold in_valid until it is accepted; in_valid stays high.
  task automatic send(input int w, input logic [63:0] v, output int acc_cyc);
    int n;
    in_value = v;
    iv[w] = 1'b1;
    n = 0;
    @(negedge clk);
    while (!ir[w] && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq($sformatf("accept_ready_%0d", w), 160'(ir[w]), 160'd1);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sbq[0].size() + sbq[1].size() + sbq[2].size()) != 0 && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("drain", 160'(sbq[0].size() + sbq[1].size() + sbq[2].size()), 160'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, t2;
    bit seen;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("rst_in_ready_%0d", k), 160'(ir[k]), 160'd0);
      check_eq($sformatf("rst_out_valid_%0d", k), 160'(ov[k]), 160'd0);
      check_eq($sformatf("rst_string_%0d", k), os[k], 160'd0);
      check_eq($sformatf("rst_ndigits_%0d", k), 160'(nd[k]), 160'd0);
      check_eq($sformatf("rst_overflow_%0d", k), 160'(ovfl[k]), 160'd0);
    end
    rst_n = 1'b1;
    #1;
    for (int k = 0; k < 3; k++)
      check_eq($sformatf("ready_after_rst_%0d", k), 160'(ir[k]), 160'd1);
    @(posedge clk);
    #1;

    // Back-to-back on zero-padded 10b/3 digits: 999, 1000 (overflow), 7, 1023
    send(0, 64'd999, t0);
    send(0, 64'd1000, t1);
    check_eq("b2b_spacing_1", 160'(t1 - t0), 160'd13);
    send(0, 64'd7, t2);
    check_eq("b2b_spacing_2", 160'(t2 - t1), 160'd13);
    send(0, 64'd1023, t0);
    iv[0] = 1'b0;
    wait_drain();

    // Space-padded: 0, 7, 42, 999, 1000
    send(1, 64'd0, t0);
    send(1, 64'd7, t0);
    send(1, 64'd42, t0);
    send(1, 64'd999, t0);
    send(1, 64'd1000, t0);
    iv[1] = 1'b0;
    wait_drain();

    // Default config, maximum value, consumer stalls 5 cycles with in_valid junk
    ordy[2] = 1'b0;
    send(2, 64'hFFFF_FFFF, t0);
    in_value = 64'd12345;
    begin
      int n;
      n = 0;
      while (!ov[2] && n < 100) begin
        @(posedge clk);
        #1;
        n++;
      end
    end
    check_eq("max_string_literal", os[2], 160'h34323934393637323935);
    for (int i = 0; i < 5; i++) begin
      check_eq("hold_valid", 160'(ov[2]), 160'd1);
      check_eq("hold_in_ready", 160'(ir[2]), 160'd0);
      check_eq("hold_string", os[2], (sbq[2].size() != 0) ? sbq[2][0].s : 160'd0);
      check_eq("hold_ndigits", 160'(nd[2]), 160'd10);
      check_eq("hold_overflow", 160'(ovfl[2]), 160'd0);
      @(posedge clk);
      #1;
    end
    iv[2] = 1'b0;
    ordy[2] = 1'b1;
    wait_drain();

    // More default-config values
    send(2, 64'd0, t0);
    send(2, 64'd1, t1);
    check_eq("b2b_spacing_c", 160'(t1 - t0), 160'd35);
    send(2, 64'd1000000000, t0);
    send(2, 64'd123456789, t0);
    iv[2] = 1'b0;
    wait_drain();

    // Reset during the fourth SHIFT cycle aborts the conversion
    send(0, 64'd500, t0);
    iv[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("abort_ready_in_rst", 160'(ir[0]), 160'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check_eq("abort_ready_after", 160'(ir[0]), 160'd1);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      seen = seen | ov[0];
    end
    check_eq("abort_no_valid", 160'(seen), 160'd0);
    @(posedge clk);
    #1;
    send(0, 64'd321, t0);
    iv[0] = 1'b0;
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
